// File: rtl/msx_debug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msx_debug_pkg                                                        |
// | ASCII codes, FSM encodings and hex decoding for the debug cmd RX.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package msx_debug_pkg;

  localparam logic [7:0] C_ASCII_CR   = 8'h0D;
  localparam logic [7:0] C_ASCII_LF   = 8'h0A;
  localparam logic [7:0] C_ASCII_B    = 8'h42;
  localparam logic [7:0] C_ASCII_B_LC = 8'h62;
  localparam logic [7:0] C_ASCII_S    = 8'h53;
  localparam logic [7:0] C_ASCII_S_LC = 8'h73;
  localparam logic [7:0] C_ASCII_X    = 8'h58;
  localparam logic [7:0] C_ASCII_X_LC = 8'h78;

  localparam logic [2:0] R_WAITIDLE = 3'd0;
  localparam logic [2:0] R_IDLE     = 3'd1;
  localparam logic [2:0] R_START    = 3'd2;
  localparam logic [2:0] R_DATA     = 3'd3;
  localparam logic [2:0] R_STOP     = 3'd4;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_ADDR  = 3'd1;
  localparam logic [2:0] P_EOL_S = 3'd2;
  localparam logic [2:0] P_EOL_X = 3'd3;
  localparam logic [2:0] P_ERR   = 3'd4;

  // Returns {valid, nibble}; nibble is zero when the byte is not a hex digit.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_8n1                                                          |
// | 8N1 deserialiser with input synchroniser and stop-bit checking.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_8n1
  import msx_debug_pkg::*;
#(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int         C_DIV       = CLK_FREQ / BAUD;
  localparam int         C_CW        = $clog2(C_DIV + 1);
  localparam logic [C_CW-1:0] C_DIV_LAST  = C_CW'(C_DIV - 1);
  localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'(C_DIV / 2 - 1);

  logic            sync1_q, sync2_q;
  logic [2:0]      state_q, state_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_WAITIDLE: if (sync2_q) state_d = R_IDLE;
      R_IDLE: begin
        if (!sync2_q) begin
          cnt_d   = '0;
          state_d = R_START;
        end
      end
      R_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = R_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = R_WAITIDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = R_WAITIDLE;
    endcase
  end

  // Synchroniser resets low so a line held low through reset is not mistaken for idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= R_WAITIDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule
`default_nettype wire

// File: rtl/msx_debug_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msx_debug_cmd_rx                                                     |
// | Host UART command receiver: watch address set/clear and dump request.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module msx_debug_cmd_rx
  import msx_debug_pkg::*;
#(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk_27m,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] watch_addr,
  output logic        watch_en,
  output logic        send_req,
  output logic        cmd_err
);

  logic [7:0]  w_byte;
  logic        w_valid, w_ferr, w_eol, w_abort;
  logic [4:0]  w_hex;

  logic [2:0]  pstate_q, pstate_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] addr_q, addr_d;
  logic        en_q, en_d;
  logic        send_q, send_d;
  logic        cerr_q, cerr_d;

  uart_rx_8n1 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk_i       (clk_27m),
    .rst_i       (reset),
    .rx_i        (uart_rx),
    .data_o      (w_byte),
    .valid_o     (w_valid),
    .frame_err_o (w_ferr)
  );

  assign w_hex   = hex_to_nibble(w_byte);
  assign w_eol   = (w_byte == C_ASCII_CR) || (w_byte == C_ASCII_LF);
  // A broken frame mid-command reports cmd_err alongside frame_err, not a cycle later.
  assign w_abort = w_ferr && (pstate_q != P_IDLE);

  always_comb begin
    pstate_d = pstate_q;
    dcnt_d   = dcnt_q;
    shreg_d  = shreg_q;
    addr_d   = addr_q;
    en_d     = en_q;
    send_d   = 1'b0;
    cerr_d   = 1'b0;
    if (w_abort) begin
      pstate_d = P_IDLE;
    end else if (w_valid) begin
      case (pstate_q)
        P_IDLE: begin
          if (w_byte == C_ASCII_B || w_byte == C_ASCII_B_LC) begin
            dcnt_d   = 3'd0;
            shreg_d  = 16'h0000;
            pstate_d = P_ADDR;
          end else if (w_byte == C_ASCII_S || w_byte == C_ASCII_S_LC) begin
            pstate_d = P_EOL_S;
          end else if (w_byte == C_ASCII_X || w_byte == C_ASCII_X_LC) begin
            pstate_d = P_EOL_X;
          end else if (!w_eol) begin
            pstate_d = P_ERR;
          end
        end
        P_ADDR: begin
          if (w_hex[4] && dcnt_q < 3'd4) begin
            shreg_d = {shreg_q[11:0], w_hex[3:0]};
            dcnt_d  = dcnt_q + 3'd1;
          end else if (w_eol) begin
            if (dcnt_q == 3'd4) begin
              addr_d = shreg_q;
              en_d   = 1'b1;
            end else begin
              cerr_d = 1'b1;
            end
            pstate_d = P_IDLE;
          end else begin
            pstate_d = P_ERR;
          end
        end
        P_EOL_S: begin
          send_d   = w_eol;
          pstate_d = w_eol ? P_IDLE : P_ERR;
        end
        P_EOL_X: begin
          if (w_eol) en_d = 1'b0;
          pstate_d = w_eol ? P_IDLE : P_ERR;
        end
        P_ERR: begin
          if (w_eol) begin
            cerr_d   = 1'b1;
            pstate_d = P_IDLE;
          end
        end
        default: pstate_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_27m) begin
    if (reset) begin
      pstate_q <= P_IDLE;
      dcnt_q   <= 3'd0;
      shreg_q  <= 16'h0000;
      addr_q   <= 16'h0000;
      en_q     <= 1'b0;
      send_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      dcnt_q   <= dcnt_d;
      shreg_q  <= shreg_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      send_q   <= send_d;
      cerr_q   <= cerr_d;
    end
  end

  assign rx_data    = w_byte;
  assign rx_valid   = w_valid;
  assign frame_err  = w_ferr;
  assign watch_addr = addr_q;
  assign watch_en   = en_q;
  assign send_req   = send_q;
  assign cmd_err    = cerr_q | w_abort;

endmodule
`default_nettype wire

// File: tb/tb_msx_debug_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_msx_debug_cmd_rx                                                  |
// | Line-level command model plus directed serial stimulus.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_msx_debug_cmd_rx;

  localparam int DIV = 27000000 / 115200;

  logic        clk_27m = 1'b0;
  logic        reset   = 1'b1;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, watch_en, send_req, cmd_err;
  logic [15:0] watch_addr;

  msx_debug_cmd_rx dut (
    .clk_27m    (clk_27m),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .watch_addr (watch_addr),
    .watch_en   (watch_en),
    .send_req   (send_req),
    .cmd_err    (cmd_err)
  );

  always #5 clk_27m = ~clk_27m;

  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_send = 0, n_cerr = 0, n_ferr = 0;
  int s_valid, s_send, s_cerr, s_ferr;

  logic [7:0]  exp_q[$];
  logic [7:0]  line_q[$];
  logic [15:0] m_addr = 16'h0000;
  logic        m_en = 1'b0, exp_send = 1'b0, exp_cerr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c >= "a") return 4'(c - "a" + 10);
    if (c >= "A") return 4'(c - "A" + 10);
    return 4'(c - "0");
  endfunction

  // Whole-line interpretation: bytes collect until an end-of-line, then the line is judged.
  task automatic model_byte(input logic [7:0] c);
    logic [7:0]  first;
    logic [15:0] v;
    bit          ok;
    if (c == 8'h0D || c == 8'h0A) begin
      if (line_q.size() != 0) begin
        first = line_q[0];
        if ((first == "S" || first == "s") && line_q.size() == 1) exp_send = 1'b1;
        else if ((first == "X" || first == "x") && line_q.size() == 1) m_en = 1'b0;
        else if (first == "B" || first == "b") begin
          ok = 1'b1;
          v  = 16'h0000;
          for (int i = 1; i < line_q.size(); i++) begin
            if (!is_hex(line_q[i])) ok = 1'b0;
            else v = {v[11:0], hex_val(line_q[i])};
          end
          if (ok && line_q.size() == 5) begin
            m_addr = v;
            m_en   = 1'b1;
          end else begin
            exp_cerr = 1'b1;
          end
        end else begin
          exp_cerr = 1'b1;
        end
        line_q.delete();
      end
    end else begin
      line_q.push_back(c);
    end
  endtask

  always @(negedge clk_27m) begin
    logic [7:0] b;
    if (reset) begin
      exp_q.delete();
      line_q.delete();
      m_addr   = 16'h0000;
      m_en     = 1'b0;
      exp_send = 1'b0;
      exp_cerr = 1'b0;
    end else begin
      chk("send_req", 32'(send_req), 32'(exp_send));
      chk("cmd_err", 32'(cmd_err), 32'(exp_cerr | (frame_err && line_q.size() != 0)));
      chk("watch_addr", 32'(watch_addr), 32'(m_addr));
      chk("watch_en", 32'(watch_en), 32'(m_en));
      n_send  += int'(send_req);
      n_cerr  += int'(cmd_err);
      n_valid += int'(rx_valid);
      n_ferr  += int'(frame_err);
      exp_send = 1'b0;
      exp_cerr = 1'b0;
      if (frame_err) line_q.delete();
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_valid: unexpected byte %h, none pending", rx_data);
        end else begin
          b = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(b));
          model_byte(b);
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk_27m);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop, DIV);
    if (!stop) hold(1'b1, DIV);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      exp_q.push_back(s[i]);
      send_frame(s[i], 1'b1);
    end
    hold(1'b1, 40);
  endtask

  task automatic snap();
    s_valid = n_valid;
    s_send  = n_send;
    s_cerr  = n_cerr;
    s_ferr  = n_ferr;
  endtask

  initial begin
    repeat (5) @(posedge clk_27m);
    #1;
    reset = 1'b0;
    chk("reset rx_data", 32'(rx_data), 32'h00);
    chk("reset watch_addr", 32'(watch_addr), 32'h0000);
    chk("reset watch_en", 32'(watch_en), 32'h0);
    chk("reset pulses", {28'h0, rx_valid, frame_err, send_req, cmd_err}, 32'h0);
    hold(1'b1, 20);

    snap();
    send_str("B7A24\r");
    chk("B7A24 rx_valid count", 32'(n_valid - s_valid), 32'd6);
    chk("B7A24 watch_addr", 32'(watch_addr), 32'h7A24);
    chk("B7A24 watch_en", 32'(watch_en), 32'h1);
    chk("B7A24 cmd_err count", 32'(n_cerr - s_cerr), 32'd0);

    snap();
    send_str("s\r\n");
    chk("s send_req count", 32'(n_send - s_send), 32'd1);
    chk("s cmd_err count", 32'(n_cerr - s_cerr), 32'd0);

    snap();
    send_str("B12\n");
    chk("B12 cmd_err count", 32'(n_cerr - s_cerr), 32'd1);
    chk("B12 watch_addr", 32'(watch_addr), 32'h7A24);
    chk("B12 watch_en", 32'(watch_en), 32'h1);
    send_str("x\n");
    chk("x watch_en", 32'(watch_en), 32'h0);
    chk("x watch_addr", 32'(watch_addr), 32'h7A24);

    snap();
    send_str("Bzz12\n");
    send_str("B00ff\n");
    chk("Bzz cmd_err count", 32'(n_cerr - s_cerr), 32'd1);
    chk("B00ff watch_addr", 32'(watch_addr), 32'h00FF);
    chk("B00ff watch_en", 32'(watch_en), 32'h1);

    snap();
    send_str("B");
    send_frame(8'h41, 1'b0);
    hold(1'b1, 40);
    chk("badstop frame_err count", 32'(n_ferr - s_ferr), 32'd1);
    chk("badstop cmd_err count", 32'(n_cerr - s_cerr), 32'd1);
    chk("badstop rx_data kept", 32'(rx_data), 32'h42);
    chk("badstop watch_addr", 32'(watch_addr), 32'h00FF);

    snap();
    hold(1'b0, 50);
    hold(1'b1, DIV);
    chk("glitch rx_valid count", 32'(n_valid - s_valid), 32'd0);
    chk("glitch frame_err count", 32'(n_ferr - s_ferr), 32'd0);

    hold(1'b0, 300);
    reset = 1'b1;
    hold(1'b0, 4);
    reset = 1'b0;
    chk("midreset rx_data", 32'(rx_data), 32'h00);
    chk("midreset watch_addr", 32'(watch_addr), 32'h0000);
    chk("midreset watch_en", 32'(watch_en), 32'h0);
    snap();
    hold(1'b0, 600);
    hold(1'b1, 1800);
    chk("postreset rx_valid count", 32'(n_valid - s_valid), 32'd0);
    chk("postreset frame_err count", 32'(n_ferr - s_ferr), 32'd0);
    send_str("s\r");
    chk("postreset rx_data", 32'(rx_data), 32'h0D);
    chk("postreset rx_valid count2", 32'(n_valid - s_valid), 32'd2);
    chk("postreset send_req count", 32'(n_send - s_send), 32'd1);

    chk("pending bytes", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
